// File: rtl/convergent_bcd_display_if.sv
// convergent_bcd_display_if: start/digit buttons, P/Q inputs and display outputs of the display stage
interface convergent_bcd_display_if;
    logic        start;
    logic        next_digit;
    logic [15:0] p_in;
    logic [15:0] q_in;
    logic [7:0]  seg_out;
    logic        busy;
    logic        done;
    modport master (output start, next_digit, p_in, q_in, input seg_out, busy, done);
    modport slave  (input start, next_digit, p_in, q_in, output seg_out, busy, done);
endinterface

// File: rtl/convergent_bcd_display.sv
// convergent_bcd_display: shared double-dabble P/Q to decimal, one digit at a time on seven-segment; LEADING_ZERO_BLANK_EN blanks leading zeros
module convergent_bcd_display (
    input  logic                     clk,
    input  logic                     rst_n,
    convergent_bcd_display_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CONV_P, CONV_Q, SHOW} state_t;
    state_t      r_state, w_state_nxt;
    logic        r_start_prev, r_next_prev, r_done;
    logic [15:0] r_bin;
    logic [19:0] r_bcd, r_p_bcd, r_q_bcd;
    logic [3:0]  r_cnt, r_idx;
    logic [7:0]  r_seg;
    logic        w_start_edge, w_next_edge, w_last, w_in_q, w_blank, w_unused;
    logic [19:0] w_adj, w_bcd_nxt, w_val;
    logic [2:0]  w_pos;
    logic [4:0]  w_sh;
    logic [3:0]  w_dig;
    logic [6:0]  w_pat;
    logic [7:0]  w_seg;

    assign w_start_edge = bus.start & ~r_start_prev;
    assign w_next_edge  = bus.next_digit & ~r_next_prev;
    assign w_last       = r_cnt == 4'd15;

    for (genvar d = 0; d < 5; d++) begin : g_adj
        assign w_adj[4*d+:4] = (r_bcd[4*d+:4] >= 4'd5) ? r_bcd[4*d+:4] + 4'd3 : r_bcd[4*d+:4];
    end
    assign w_bcd_nxt = {w_adj[18:0], r_bin[15]};
    assign w_unused  = w_adj[19];

    // next-state: conversions run a fixed 16 shifts each, start restarts from IDLE or SHOW only
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_start_edge ? CONV_P : IDLE;
            CONV_P:  w_state_nxt = w_last ? CONV_Q : CONV_P;
            CONV_Q:  w_state_nxt = w_last ? SHOW : CONV_Q;
            default: w_state_nxt = w_start_edge ? CONV_P : SHOW;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // datapath: edge registers, double-dabble shifter, result latches, digit index, done pulse, segment register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_prev <= 1'b0;
            r_next_prev  <= 1'b0;
            r_done       <= 1'b0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_p_bcd      <= '0;
            r_q_bcd      <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_seg        <= '0;
        end else begin
            r_start_prev <= bus.start;
            r_next_prev  <= bus.next_digit;
            r_done       <= 1'b0;
            r_seg        <= w_seg;
            if (r_state == CONV_P || r_state == CONV_Q) begin
                r_bin <= {r_bin[14:0], 1'b0};
                r_bcd <= w_bcd_nxt;
                r_cnt <= r_cnt + 4'd1;
                if (w_last && r_state == CONV_P) begin
                    r_p_bcd <= w_bcd_nxt;
                    r_bin   <= bus.q_in;
                    r_bcd   <= '0;
                end else if (w_last) begin
                    r_q_bcd <= w_bcd_nxt;
                    r_idx   <= '0;
                    r_done  <= 1'b1;
                end
            end else if (w_start_edge) begin
                r_bin <= bus.p_in;
                r_bcd <= '0;
                r_cnt <= '0;
            end else if (r_state == SHOW && w_next_edge) begin
                r_idx <= (r_idx == 4'd9) ? 4'd0 : r_idx + 4'd1;
            end
        end
    end

    assign w_in_q = r_idx >= 4'd5;
    assign w_pos  = 3'(w_in_q ? r_idx - 4'd5 : r_idx);
    assign w_val  = w_in_q ? r_q_bcd : r_p_bcd;
    assign w_sh   = 5'd16 - {w_pos, 2'b00};
    assign w_dig  = 4'(w_val >> w_sh);
`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank = (w_pos != 3'd4) && ((w_val >> w_sh) == 20'd0);
`else
    assign w_blank = 1'b0;
`endif

    // digit decode to segment pattern, dp marks the Q half
    always_comb begin
        w_pat = 7'h00;
        case (w_dig)
            4'd0: w_pat = 7'h3F;
            4'd1: w_pat = 7'h06;
            4'd2: w_pat = 7'h5B;
            4'd3: w_pat = 7'h4F;
            4'd4: w_pat = 7'h66;
            4'd5: w_pat = 7'h6D;
            4'd6: w_pat = 7'h7D;
            4'd7: w_pat = 7'h07;
            4'd8: w_pat = 7'h7F;
            4'd9: w_pat = 7'h6F;
            default: w_pat = 7'h00;
        endcase
        w_seg = (r_state == SHOW) ? {w_in_q, w_blank ? 7'h00 : w_pat} : 8'h00;
    end

    assign bus.seg_out = r_seg;
    assign bus.busy    = (r_state == CONV_P) || (r_state == CONV_Q);
    assign bus.done    = r_done;
endmodule

// File: tb/tb_convergent_bcd_display.sv
// tb_convergent_bcd_display: scoreboard bench, decimal reference model, directed and random P/Q pairs
module tb_convergent_bcd_display;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic smp = 1'b0;
    int cyc = 0;
    int passed = 0;
    int total = 0;
    int cur_p, cur_q, cur_idx;
    typedef struct { string name; int kind; int exp; } chk_t;
    chk_t chk_q[$];
    int done_q[$];
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int pw [5] = '{10000, 1000, 100, 10, 1};

    convergent_bcd_display_if bus();
    convergent_bcd_display dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every done pulse is matched against the expected completion cycle; sampled checks popped on smp
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            total++;
            if (done_q.size() == 0) $display("FAIL done_unexpected actual=pulse at cycle %0d required=none", cyc);
            else begin
                int e;
                e = done_q.pop_front();
                if (cyc == e) passed++;
                else $display("FAIL done_cycle actual=%0d required=%0d", cyc, e);
            end
        end
        if (smp) while (chk_q.size() > 0) begin
            chk_t c;
            int act;
            c = chk_q.pop_front();
            act = (c.kind == 0) ? int'(bus.seg_out) : (c.kind == 1) ? int'(bus.busy) : int'(bus.done);
            total++;
            if (act == c.exp) passed++;
            else $display("FAIL %s actual=%0h required=%0h", c.name, act, c.exp);
        end
    end

    function automatic int model_seg(input int p, input int q, input int idx);
        int v, k, d;
        logic [6:0] pat;
        v = (idx < 5) ? p : q;
        k = idx % 5;
        d = (v / pw[k]) % 10;
        pat = seg_tab[d];
`ifdef LEADING_ZERO_BLANK_EN
        if (k < 4 && v / pw[k] == 0) pat = 7'h00;
`endif
        return {24'd0, idx >= 5, pat};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int kind, input int exp);
        chk_q.push_back('{name, kind, exp});
        smp = 1'b1;
        tick();
        smp = 1'b0;
    endtask

    task automatic do_start(input int p, input int q, input logic nd);
        bus.p_in = 16'(p);
        bus.q_in = 16'(q);
        bus.start = 1'b1;
        bus.next_digit = nd;
        done_q.push_back(cyc + 33);
        cur_p = p;
        cur_q = q;
        cur_idx = 0;
        tick();
        bus.start = 1'b0;
        bus.next_digit = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (bus.done !== 1'b1) begin
            total++;
            $display("FAIL done_timeout actual=none required=pulse within 40 cycles");
            if (done_q.size() > 0) void'(done_q.pop_front());
        end
        tick();
    endtask

    task automatic step();
        bus.next_digit = 1'b1;
        tick();
        bus.next_digit = 1'b0;
        tick();
        cur_idx = (cur_idx + 1) % 10;
    endtask

    task automatic check_digit();
        check($sformatf("seg_idx%0d_p%0d_q%0d", cur_idx, cur_p, cur_q), 0, model_seg(cur_p, cur_q, cur_idx));
    endtask

    task automatic sweep();
        check_digit();
        repeat (10) begin
            step();
            check_digit();
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.next_digit = 1'b0;
        bus.p_in = '0;
        bus.q_in = '0;
        tick();
        tick();
        check("rst_seg", 0, 0);
        check("rst_busy", 1, 0);
        check("rst_done", 2, 0);
        rst_n = 1'b1;
        tick();

        do_start(1393, 985, 1'b0);
        check("conv_busy", 1, 1);
        check("conv_seg", 0, 0);
        wait_done();
        check("show_busy", 1, 0);
        sweep();
        step();
        check_digit();

        do_start(65535, 0, 1'b0);
        wait_done();
        sweep();

        do_start(4321, 1234, 1'b0);
        repeat (8) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ignored_start_busy", 1, 1);
        wait_done();
        sweep();

        repeat (3) step();
        do_start(50607, 89, 1'b1);
        check("restart_busy", 1, 1);
        check("restart_seg", 0, 0);
        wait_done();
        check_digit();
        step();
        check_digit();

        for (int i = 0; i < 6; i++) begin
            int p, q;
            p = (i % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 999));
            q = (i % 3 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 65535));
            do_start(p, q, 1'b0);
            wait_done();
            sweep();
        end

        do_start(777, 888, 1'b0);
        repeat (18) tick();
        rst_n = 1'b0;
        void'(done_q.pop_back());
        check("arst_conv_busy", 1, 0);
        check("arst_conv_done", 2, 0);
        rst_n = 1'b1;
        repeat (40) tick();
        check("idle_after_rst_seg", 0, 0);
        check("idle_after_rst_busy", 1, 0);

        do_start(12345, 6789, 1'b0);
        wait_done();
        check_digit();
        rst_n = 1'b0;
        check("arst_show_seg", 0, 0);
        rst_n = 1'b1;
        tick();
        check("idle_after_show_rst_seg", 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
